// File: rtl/fp16_norm_round.sv
// FP16 add/sub back end: normalizes the raw magnitude sum from the adder stage,
// rounds to nearest-even and packs an IEEE-754 binary16 result.
// Two registered stages (leading-zero count, then shift/round/pack) with
// valid/ready flow control on both sides.
module fp16_norm_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [4:0]  in_exp,
  input  logic [21:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_overflow,
  output logic        out_inexact
);

  // Stage 0 state: operand plus the normalization decision
  logic        s0_valid_q;
  logic        s0_sign_q;
  logic [21:0] s0_mant_q;
  logic        s0_zero_q,  s0_zero_d;
  logic        s0_rsh_q,   s0_rsh_d;   // carry-out: shift right by one
  logic [4:0]  s0_shl_q,   s0_shl_d;   // left shift amount otherwise
  logic [6:0]  s0_exp_q,   s0_exp_d;   // never negative, so kept unsigned

  // Output stage state
  logic        out_valid_q;
  logic [15:0] out_data_q,  out_data_d;
  logic        out_ovf_q,   out_ovf_d;
  logic        out_inx_q,   out_inx_d;

  logic        s0_en, s1_en;
  logic [4:0]  lz;

  // A stage can advance when it is empty or its consumer is advancing
  assign s1_en    = !out_valid_q | out_ready;
  assign s0_en    = !s0_valid_q  | s1_en;
  assign in_ready = s0_en;

  // Leading zeros of the integer+fraction field; 21 only when it is all zero
  always_comb begin
    lz = 5'd21;
    for (int i = 0; i < 21; i++)
      if (in_mant[i]) lz = 5'(20 - i);
  end

  // Normalization decision: right-shift on carry, left-shift on cancellation,
  // and clamp to the denormal range when the exponent would run out
  always_comb begin
    s0_zero_d = (in_mant == 22'd0);
    s0_rsh_d  = 1'b0;
    s0_shl_d  = 5'd0;
    s0_exp_d  = 7'd0;
    if (in_mant[21]) begin
      s0_rsh_d = 1'b1;
      s0_exp_d = {2'b00, in_exp} + 7'd1;
    end else if (lz < in_exp) begin
      s0_shl_d = lz;
      s0_exp_d = {2'b00, in_exp} - {2'b00, lz};
    end else begin
      s0_shl_d = in_exp - 5'd1;
      s0_exp_d = 7'd0;
    end
  end

  // Stage 0 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_sign_q  <= 1'b0;
      s0_mant_q  <= 22'd0;
      s0_zero_q  <= 1'b0;
      s0_rsh_q   <= 1'b0;
      s0_shl_q   <= 5'd0;
      s0_exp_q   <= 7'd0;
    end else if (s0_en) begin
      s0_valid_q <= in_valid;
      if (in_valid) begin
        s0_sign_q <= in_sign;
        s0_mant_q <= in_mant;
        s0_zero_q <= s0_zero_d;
        s0_rsh_q  <= s0_rsh_d;
        s0_shl_q  <= s0_shl_d;
        s0_exp_q  <= s0_exp_d;
      end
    end
  end

  // Shift, round-to-nearest-even and pack
  logic [19:0] m;
  logic [9:0]  frac;
  logic        guard, sticky, rnd;
  logic [10:0] frac_sum;
  logic [6:0]  e_r;

  always_comb begin
    // Bits above the integer position are zero after normalization
    m        = 20'(s0_rsh_q ? (s0_mant_q >> 1) : (s0_mant_q << s0_shl_q));
    frac     = m[19:10];
    guard    = m[9];
    sticky   = (|m[8:0]) | (s0_rsh_q & s0_mant_q[0]);
    rnd      = guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + {10'd0, rnd};
    // Fraction carry bumps the exponent; also promotes a denormal to e=1
    e_r      = s0_exp_q + {6'd0, frac_sum[10]};
    out_data_d = {s0_sign_q, e_r[4:0], frac_sum[9:0]};
    out_ovf_d  = 1'b0;
    out_inx_d  = guard | sticky;
    if (s0_zero_q) begin
      out_data_d = 16'h0000;
      out_inx_d  = 1'b0;
    end else if (e_r >= 7'd31) begin
      out_data_d = {s0_sign_q, 5'h1F, 10'h000};
      out_ovf_d  = 1'b1;
      out_inx_d  = 1'b1;
    end
  end

  // Output register; holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_ovf_q   <= 1'b0;
      out_inx_q   <= 1'b0;
    end else if (s1_en) begin
      out_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        out_data_q <= out_data_d;
        out_ovf_q  <= out_ovf_d;
        out_inx_q  <= out_inx_d;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_overflow = out_ovf_q;
  assign out_inexact  = out_inx_q;

endmodule
